enemy_hit_judge: RTL and testbench
==================================

Name: enemy_hit_judge

Overview:
- Consumer side of the bullet interface: receives the bullet position and in-flight flag from the bullet logic, tests them against one enemy box, and returns the `boom` pulse that retires the bullet.
- Owns the enemy life cycle (alive, explosion animation, respawn delay) and a hit score.
- Also produces the enemy/explosion pixel layer for the VGA mixer, using the same x/y scan interface as the bullet layer.

Parameters:
- E_W, 32, enemy box width in pixels
- E_H, 32, enemy box height in pixels
- B_W, 4, bullet box width in pixels
- B_H, 8, bullet box height in pixels
- Y_BIAS, 480, bias added to all object y coordinates (screen row = coord − Y_BIAS)
- BOOM_FRAMES, 16, explosion length in frames
- RESPAWN_FRAMES, 60, dead time in frames before respawn
- ENEMY_RGB, 12'hF00, enemy colour
- BOOM_RGB, 12'hFF0, explosion colour

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse per frame, issued in vblank while positions are stable
- b_valid  in  1  bullet in flight
- b_x  in  10  bullet top-left x
- b_y  in  10  bullet top-left y, biased
- e_x  in  10  enemy top-left x, from movement logic
- e_y  in  10  enemy top-left y, biased
- x  in  10  scan pixel column
- y  in  10  scan pixel row, unbiased
- boom  out  1  one-clk hit pulse to the bullet logic
- enemy_alive  out  1  high only in state ALIVE
- score  out  8  hit count, saturating
- enemy_rgb  out  12  pixel colour
- enemy_en  out  1  pixel valid

Behaviour:
- **Reset (rst=0, asynchronous):**
  - state=ALIVE, frame counter cnt=0, score=0.
  - boom=0, enemy_en=0, enemy_rgb=0, enemy_alive=1.
  - Latched explosion position = 0.
- **Overlap test (combinational):**
  - `hit_c = b_valid & (b_x < e_x+E_W) & (e_x < b_x+B_W) & (b_y < e_y+E_H) & (e_y < b_y+B_H)`.
  - All sums are 11-bit, so there is no wrap. Comparisons are strict: boxes that only touch at an edge do not hit.
- **State machine.** Transitions occur only on clk edges with frame_tick=1.
  - ALIVE: if hit_c, then:
    - boom=1 for exactly the next clk;
    - score+1, saturating at 255;
    - latch (e_x, e_y) into (lx, ly);
    - cnt=0; go to EXPLODE.
  - EXPLODE:
    - cnt+1 per frame_tick;
    - on a frame_tick with cnt==BOOM_FRAMES−1, set cnt=0 and go to DEAD.
    - Bullets are ignored: no boom, no score change.
  - DEAD:
    - cnt+1 per frame_tick;
    - on a frame_tick with cnt==RESPAWN_FRAMES−1, set cnt=0 and go to ALIVE.
    - Bullets are ignored.
- **boom timing:**
  - boom is registered: it is high in the cycle after the detecting frame_tick, then low.
  - hit_c while frame_tick=0 has no effect.
  - b_valid=0 means no hit, regardless of position.
- **Render path:**
  - yb = y + Y_BIAS (11-bit).
  - in_box means x in [bx, bx+E_W) and yb in [by, by+E_H).
  - Box origin: ALIVE uses (e_x, e_y); EXPLODE uses (lx, ly).
  - Colour selection:
    - ALIVE and in_box: enemy_en=1, enemy_rgb=ENEMY_RGB.
    - EXPLODE and in_box and cnt[1]==0: enemy_en=1, enemy_rgb=BOOM_RGB (flashing explosion).
    - Otherwise, including DEAD: enemy_en=0, enemy_rgb=0.
  - Outputs are registered, so latency is 1 clk from x/y.
- **Other rules:**
  - Reset asserted in any state returns to the reset values immediately.
  - score is never cleared except by reset.

Test Plan:
- Hit: defaults, e=(260,900), b=(270,910), b_valid=1, one frame_tick → boom=1 for exactly one clk, on the clk after the tick; score=1; enemy_alive=0 from that cycle.
- Edge: b_x=292, other values as in the hit case, frame_tick → no boom, score 0. Then b_x=291 → boom, score 1. Then, after respawn, b_x=256 (b_x+B_W = e_x) → no boom.
- Lifecycle:
  - After a hit, enemy_alive stays 0 for 16+60 frame_ticks and returns to 1 on the 76th.
  - A bullet overlapping during EXPLODE/DEAD gives no boom and leaves score unchanged.
  - frame_tick held low → state frozen.
- Render:
  - ALIVE, e=(260,900), scan x=270, y=430 → one clk later enemy_en=1, enemy_rgb=F00.
  - x=292 → enemy_en=0.
  - EXPLODE with cnt=0 → FF0.
  - EXPLODE with cnt=2 → en=0.
  - DEAD → en=0.
- Saturation and reset: after 300 hits with respawns, score=255. Assert rst=0 mid-EXPLODE → score=0, enemy_alive=1, boom=0, enemy_en=0 without waiting for clk.

Source files
------------

// File: rtl/enemy_hit_judge.sv
// Enemy box: bullet hit test, alive/explode/dead life cycle, saturating score and pixel layer.
// boom and pixel outputs are registered (1 clk); no backpressure, state advances only on frame_tick.
module enemy_hit_judge #(
  parameter int          E_W            = 32,
  parameter int          E_H            = 32,
  parameter int          B_W            = 4,
  parameter int          B_H            = 8,
  parameter int          Y_BIAS         = 480,
  parameter int          BOOM_FRAMES    = 16,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [11:0] ENEMY_RGB      = 12'hF00,
  parameter logic [11:0] BOOM_RGB       = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        b_valid,
  input  logic [9:0]  b_x,
  input  logic [9:0]  b_y,
  input  logic [9:0]  e_x,
  input  logic [9:0]  e_y,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic        boom,
  output logic        enemy_alive,
  output logic [7:0]  score,
  output logic [11:0] enemy_rgb,
  output logic        enemy_en
);

  typedef enum logic [1:0] {ALIVE, EXPLODE, DEAD} state_t;

  localparam logic [7:0] BOOM_LAST    = 8'(BOOM_FRAMES - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n, score_n;
  logic [9:0]  lx, ly, lx_n, ly_n;
  logic        boom_n;
  logic        hit_c;

  // 11-bit sums keep the box edges from wrapping near the 10-bit limit
  logic [10:0] ex_end, ey_end, bx_end, by_end;
  assign ex_end = {1'b0, e_x} + 11'(E_W);
  assign ey_end = {1'b0, e_y} + 11'(E_H);
  assign bx_end = {1'b0, b_x} + 11'(B_W);
  assign by_end = {1'b0, b_y} + 11'(B_H);

  assign hit_c = b_valid
               & ({1'b0, b_x} < ex_end) & ({1'b0, e_x} < bx_end)
               & ({1'b0, b_y} < ey_end) & ({1'b0, e_y} < by_end);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    score_n = score;
    lx_n    = lx;
    ly_n    = ly;
    boom_n  = 1'b0;
    if (frame_tick) begin
      case (state)
        ALIVE: begin
          if (hit_c) begin
            boom_n  = 1'b1;
            score_n = (score == 8'hFF) ? score : score + 8'd1;
            lx_n    = e_x;
            ly_n    = e_y;
            cnt_n   = 8'd0;
            state_n = EXPLODE;
          end
        end
        EXPLODE: begin
          if (cnt == BOOM_LAST) begin
            cnt_n   = 8'd0;
            state_n = DEAD;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        DEAD: begin
          if (cnt == RESPAWN_LAST) begin
            cnt_n   = 8'd0;
            state_n = ALIVE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
        default: begin
          cnt_n   = 8'd0;
          state_n = ALIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ALIVE;
      cnt   <= 8'd0;
      score <= 8'd0;
      lx    <= 10'd0;
      ly    <= 10'd0;
      boom  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      score <= score_n;
      lx    <= lx_n;
      ly    <= ly_n;
      boom  <= boom_n;
    end
  end

  assign enemy_alive = (state == ALIVE);

  // Explosion stays where the enemy was hit, even if movement logic moves e_x/e_y on
  logic [9:0]  org_x, org_y;
  logic [10:0] yb;
  logic        in_box, en_n;
  logic [11:0] rgb_n;

  assign org_x  = (state == EXPLODE) ? lx : e_x;
  assign org_y  = (state == EXPLODE) ? ly : e_y;
  assign yb     = {1'b0, y} + 11'(Y_BIAS);
  assign in_box = (x >= org_x) && ({1'b0, x} < ({1'b0, org_x} + 11'(E_W)))
               && (yb >= {1'b0, org_y}) && (yb < ({1'b0, org_y} + 11'(E_H)));

  always_comb begin
    en_n  = 1'b0;
    rgb_n = 12'h000;
    if (in_box && state == ALIVE) begin
      en_n  = 1'b1;
      rgb_n = ENEMY_RGB;
    end else if (in_box && state == EXPLODE && !cnt[1]) begin
      en_n  = 1'b1;
      rgb_n = BOOM_RGB;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enemy_en  <= 1'b0;
      enemy_rgb <= 12'h000;
    end else begin
      enemy_en  <= en_n;
      enemy_rgb <= rgb_n;
    end
  end

endmodule

// File: tb/tb_enemy_hit_judge.sv
// Bench for enemy_hit_judge: reference model feeds a queue of expected outputs, popped each clk.
module tb_enemy_hit_judge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0, b_valid = 1'b0;
  logic [9:0]  b_x = '0, b_y = '0, e_x = '0, e_y = '0, x = '0, y = '0;
  logic        boom, enemy_alive, enemy_en;
  logic [7:0]  score;
  logic [11:0] enemy_rgb;

  enemy_hit_judge dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .b_valid(b_valid),
    .b_x(b_x), .b_y(b_y), .e_x(e_x), .e_y(e_y), .x(x), .y(y),
    .boom(boom), .enemy_alive(enemy_alive), .score(score),
    .enemy_rgb(enemy_rgb), .enemy_en(enemy_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        boom;
    logic        alive;
    logic [7:0]  score;
    logic        en;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // model state: 0=alive 1=explode 2=dead
  int m_state = 0, m_cnt = 0, m_score = 0, m_lx = 0, m_ly = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_score = 0; m_lx = 0; m_ly = 0;
  endtask

  task automatic step(input logic ft, input logic bv, input int bx, input int by,
                      input int ex, input int ey, input int sx, input int sy);
    exp_t e;
    int   ox, oy;
    bit   inb, hit;
    frame_tick = ft; b_valid = bv;
    b_x = 10'(bx); b_y = 10'(by); e_x = 10'(ex); e_y = 10'(ey);
    x = 10'(sx); y = 10'(sy);
    ox  = (m_state == 1) ? m_lx : ex;
    oy  = (m_state == 1) ? m_ly : ey;
    inb = (m_state != 2) && sx >= ox && sx < ox + 32 && sy + 480 >= oy && sy + 480 < oy + 32;
    e.en  = inb && (m_state == 0 || (m_cnt & 2) == 0);
    e.rgb = !e.en ? 12'h000 : (m_state == 0 ? 12'hF00 : 12'hFF0);
    hit = bv && bx < ex + 32 && ex < bx + 4 && by < ey + 32 && ey < by + 8;
    e.boom = 1'b0;
    if (ft) begin
      case (m_state)
        0: if (hit) begin
             e.boom = 1'b1;
             if (m_score < 255) m_score++;
             m_lx = ex; m_ly = ey; m_cnt = 0; m_state = 1;
           end
        1: if (m_cnt == 15) begin m_cnt = 0; m_state = 2; end else m_cnt++;
        default: if (m_cnt == 59) begin m_cnt = 0; m_state = 0; end else m_cnt++;
      endcase
    end
    e.alive = (m_state == 0);
    e.score = 8'(m_score);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("boom",  int'(boom),        int'(e.boom));
    chk("alive", int'(enemy_alive), int'(e.alive));
    chk("score", int'(score),       int'(e.score));
    chk("en",    int'(enemy_en),    int'(e.en));
    chk("rgb",   int'(enemy_rgb),   int'(e.rgb));
  endtask

  initial begin
    int n;
    #3;
    chk("rst_boom",  int'(boom), 0);
    chk("rst_alive", int'(enemy_alive), 1);
    chk("rst_score", int'(score), 0);
    chk("rst_en",    int'(enemy_en), 0);
    chk("rst_rgb",   int'(enemy_rgb), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // render while alive
    step(0, 0, 0, 0, 260, 900, 270, 430);
    chk("alive_rgb", int'(enemy_rgb), 'hF00);
    step(0, 0, 0, 0, 260, 900, 292, 430);
    chk("alive_edge_en", int'(enemy_en), 0);
    step(0, 0, 0, 0, 260, 900, 259, 430);
    step(0, 0, 0, 0, 260, 900, 270, 450);

    // touching right edge: no hit
    step(1, 1, 292, 910, 260, 900, 270, 430);
    chk("edge_noboom", int'(boom), 0);
    // overlap without a tick, and overlap with b_valid low: no effect
    step(0, 1, 291, 910, 260, 900, 270, 430);
    step(1, 0, 291, 910, 260, 900, 270, 430);
    chk("novalid_score", int'(score), 0);
    // real hit
    step(1, 1, 291, 910, 260, 900, 270, 430);
    chk("hit_boom", int'(boom), 1);
    chk("hit_score", int'(score), 1);
    chk("hit_alive", int'(enemy_alive), 0);
    step(0, 1, 291, 910, 260, 900, 270, 430);
    chk("boom_one_clk", int'(boom), 0);
    chk("explode_rgb", int'(enemy_rgb), 'hFF0);
    // enemy moves away; explosion must stay at the latched spot
    step(0, 0, 0, 0, 500, 100, 270, 430);
    chk("explode_latched", int'(enemy_rgb), 'hFF0);
    // frozen without ticks
    repeat (5) step(0, 1, 291, 910, 260, 900, 270, 430);

    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1, 1, 291, 910, 260, 900, 270, 430);
      if (i == 3) chk("explode_cnt2_en", int'(enemy_en), 0);
      if (enemy_alive) begin n = i; break; end
    end
    chk("respawn_ticks", n, 76);
    chk("dead_score", int'(score), 1);

    // bullet right edge touching enemy left edge
    step(1, 1, 256, 910, 260, 900, 270, 430);
    chk("left_touch_noboom", int'(boom), 0);
    step(1, 1, 270, 892, 260, 900, 0, 0);
    chk("top_touch_noboom", int'(boom), 0);

    // 300 hits with full respawn each time
    for (int k = 0; k < 300; k++) begin
      step(1, 1, 257, 893, 260, 900, 200 + (k % 100), 420 + (k % 16));
      repeat (76) step(1, 0, 0, 0, 260, 900, 270, 430);
    end
    chk("sat_score", int'(score), 255);

    // async reset right after a hit, away from the clock edge
    step(1, 1, 291, 910, 260, 900, 270, 430);
    chk("pre_rst_boom", int'(boom), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_score", int'(score), 0);
    chk("arst_alive", int'(enemy_alive), 1);
    chk("arst_boom",  int'(boom), 0);
    chk("arst_en",    int'(enemy_en), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    step(0, 0, 0, 0, 260, 900, 270, 430);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
